// File: rtl/survivor_ring_if.sv
// Survivor ring bus: ACS decision delivery, traceback read port and ring status.
// Master is the ACS/traceback side; slave is the survivor ring itself.
`ifndef WD_FSM
`define WD_FSM 6
`endif
`ifndef N_ACS
`define N_ACS 4
`endif
`ifndef WD_STATE
`define WD_STATE 8
`endif

interface survivor_ring_if #(
  parameter int WD_DEPTH = 5
);
  logic                 active;
  logic                 hold;
  logic [`WD_FSM-1:0]   acs_segment;
  logic [`N_ACS-1:0]    survivors;
  logic [`WD_STATE-1:0] lowest_state;
  logic                 rd_req;
  logic [WD_DEPTH-1:0]  rd_depth;
  logic [`WD_STATE-1:0] rd_state;
  logic                 rd_valid;
  logic                 rd_bit;
  logic                 rd_miss;
  logic [WD_DEPTH-1:0]  wr_ptr;
  logic [WD_DEPTH:0]    fill;
  logic                 tb_ready;
  logic                 symbol_done;
  logic [`WD_STATE-1:0] start_state;
  logic                 seg_err;

  modport master (
    output active, hold, acs_segment, survivors, lowest_state,
    output rd_req, rd_depth, rd_state,
    input  rd_valid, rd_bit, rd_miss, wr_ptr, fill, tb_ready,
    input  symbol_done, start_state, seg_err
  );

  modport slave (
    input  active, hold, acs_segment, survivors, lowest_state,
    input  rd_req, rd_depth, rd_state,
    output rd_valid, rd_bit, rd_miss, wr_ptr, fill, tb_ready,
    output symbol_done, start_state, seg_err
  );
endinterface

// File: rtl/survivor_ring.sv
// Viterbi survivor ring: stages per-segment ACS decisions, commits one word per symbol, serves traceback reads.
// Optional feature: define SURV_SEGCHK_EN to enable the sticky segment-order checker (SegErr).
`ifndef WD_FSM
`define WD_FSM 6
`endif
`ifndef N_ACS
`define N_ACS 4
`endif
`ifndef WD_STATE
`define WD_STATE 8
`endif

module survivor_ring #(
  parameter int TB_DEPTH = 32,
  parameter int WD_DEPTH = 5
) (
  input logic           clk_i,
  input logic           rst_ni,
  survivor_ring_if.slave ring_if
);
  localparam int N_SEG  = 1 << `WD_FSM;
  localparam int W_WORD = N_SEG * `N_ACS;
  localparam logic [WD_DEPTH:0] FILL_MAX = (WD_DEPTH+1)'(TB_DEPTH);

  logic [W_WORD-1:0]    staging_q;
  logic [W_WORD-1:0]    merged_s;
  logic [W_WORD-1:0]    ring_q [TB_DEPTH];
  logic                 commit_s;
  logic [WD_DEPTH-1:0]  rd_addr_s;
  logic                 rd_miss_s;
  logic                 rd_word_bit_s;

  logic [WD_DEPTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [WD_DEPTH:0]    fill_q, fill_d;
  logic                 symbol_done_q, symbol_done_d;
  logic [`WD_STATE-1:0] start_state_q, start_state_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 rd_bit_q, rd_bit_d;
  logic                 rd_miss_q, rd_miss_d;

  assign commit_s = ring_if.active & ring_if.hold;

  // Staging word with the current cycle's segment merged in (what a commit writes)
  always_comb begin
    merged_s = staging_q;
    if (ring_if.active) begin
      merged_s[int'(ring_if.acs_segment) * `N_ACS +: `N_ACS] = ring_if.survivors;
    end else begin
      merged_s = staging_q;
    end
  end

  // Staging and ring storage: data only, deliberately not reset
  always_ff @(posedge clk_i) begin
    if (ring_if.active) begin
      staging_q <= merged_s;
    end
    if (commit_s) begin
      ring_q[wr_ptr_q] <= merged_s;
    end
  end

  // Read lookup uses pre-commit pointer/fill; the registered read sees old slot contents
  always_comb begin
    rd_addr_s     = wr_ptr_q - 1'b1 - ring_if.rd_depth;
    rd_miss_s     = ({1'b0, ring_if.rd_depth} >= fill_q);
    rd_word_bit_s = ring_q[rd_addr_s][ring_if.rd_state];
  end

  // Next-state for pointer, fill, done pulse, start state and read outputs
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    fill_d        = fill_q;
    start_state_d = start_state_q;
    if (commit_s) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end else begin
        fill_d = fill_q;
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (symbol_done_q) begin
      start_state_d = ring_if.lowest_state;
    end else begin
      start_state_d = start_state_q;
    end
    symbol_done_d = commit_s;
    rd_valid_d    = ring_if.rd_req;
    rd_miss_d     = ring_if.rd_req & rd_miss_s;
    rd_bit_d      = ring_if.rd_req & ~rd_miss_s & rd_word_bit_s;
  end

  // Control/status registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q      <= '0;
      fill_q        <= '0;
      symbol_done_q <= 1'b0;
      start_state_q <= '0;
      rd_valid_q    <= 1'b0;
      rd_bit_q      <= 1'b0;
      rd_miss_q     <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      fill_q        <= fill_d;
      symbol_done_q <= symbol_done_d;
      start_state_q <= start_state_d;
      rd_valid_q    <= rd_valid_d;
      rd_bit_q      <= rd_bit_d;
      rd_miss_q     <= rd_miss_d;
    end
  end

`ifdef SURV_SEGCHK_EN
  logic [`WD_FSM-1:0] seg_cnt_q, seg_cnt_d;
  logic               seg_err_q, seg_err_d;
  logic               last_seg_s;

  // Segment order check: expected index sequence, Hold only on the final segment
  always_comb begin
    seg_cnt_d  = seg_cnt_q;
    seg_err_d  = seg_err_q;
    last_seg_s = (ring_if.acs_segment == {`WD_FSM{1'b1}});
    if (ring_if.active) begin
      if (ring_if.hold) begin
        seg_cnt_d = '0;
      end else begin
        seg_cnt_d = seg_cnt_q + 1'b1;
      end
      if ((ring_if.acs_segment != seg_cnt_q) || (ring_if.hold != last_seg_s)) begin
        seg_err_d = 1'b1;
      end else begin
        seg_err_d = seg_err_q;
      end
    end else begin
      seg_cnt_d = seg_cnt_q;
    end
  end

  // Segment counter and sticky error flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seg_cnt_q <= '0;
      seg_err_q <= 1'b0;
    end else begin
      seg_cnt_q <= seg_cnt_d;
      seg_err_q <= seg_err_d;
    end
  end

  assign ring_if.seg_err = seg_err_q;
`else
  assign ring_if.seg_err = 1'b0;
`endif

  assign ring_if.wr_ptr      = wr_ptr_q;
  assign ring_if.fill        = fill_q;
  assign ring_if.tb_ready    = (fill_q == FILL_MAX);
  assign ring_if.symbol_done = symbol_done_q;
  assign ring_if.start_state = start_state_q;
  assign ring_if.rd_valid    = rd_valid_q;
  assign ring_if.rd_bit      = rd_bit_q;
  assign ring_if.rd_miss     = rd_miss_q;

endmodule

// File: tb/tb_survivor_ring.sv
// Directed self-checking bench for survivor_ring (TB_DEPTH=32); expected bits come from a per-symbol pattern model.
module tb_survivor_ring;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  survivor_ring_if #(.WD_DEPTH(5)) bus ();

  survivor_ring #(.TB_DEPTH(32), .WD_DEPTH(5)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .ring_if(bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Survivor nibble delivered for symbol n, segment seg
  function automatic logic [3:0] surv_of(input int n, input int seg);
    int v;
    if (n == 0) v = 10;
    else        v = (n * 7 + seg) ^ (n >> 4);
    return v[3:0];
  endfunction

  function automatic logic exp_bit(input int n, input int state);
    logic [3:0] s;
    s = surv_of(n, state >> 2);
    return s[state & 3];
  endfunction

  // Drives one full symbol; returns at the negedge after the commit edge with Active low
  task automatic send_symbol(input int n);
    for (int seg = 0; seg < 64; seg++) begin
      bus.active      = 1'b1;
      bus.acs_segment = 6'(seg);
      bus.survivors   = surv_of(n, seg);
      bus.hold        = (seg == 63);
      @(negedge clk);
    end
    bus.active = 1'b0;
    bus.hold   = 1'b0;
  endtask

  task automatic read_chk(input int depth, input int state, input logic exp_miss,
                          input logic exp_b, input string tag);
    bus.rd_req   = 1'b1;
    bus.rd_depth = 5'(depth);
    bus.rd_state = 8'(state);
    @(negedge clk);
    bus.rd_req = 1'b0;
    check_val({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
    check_val({tag, "_miss"},  32'(bus.rd_miss),  32'(exp_miss));
    check_val({tag, "_bit"},   32'(bus.rd_bit),   32'(exp_b));
  endtask

  initial begin
    bus.active = 1'b0; bus.hold = 1'b0; bus.acs_segment = '0; bus.survivors = '0;
    bus.lowest_state = '0; bus.rd_req = 1'b0; bus.rd_depth = '0; bus.rd_state = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_wr_ptr", 32'(bus.wr_ptr), 32'd0);
    check_val("rst_fill", 32'(bus.fill), 32'd0);
    check_val("rst_tb_ready", 32'(bus.tb_ready), 32'd0);
    check_val("rst_done", 32'(bus.symbol_done), 32'd0);
    check_val("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check_val("rst_start", 32'(bus.start_state), 32'd0);
    check_val("rst_seg_err", 32'(bus.seg_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // First symbol, SymbolDone pulse, StartState capture, reads of newest word
    send_symbol(0);
    check_val("s0_done", 32'(bus.symbol_done), 32'd1);
    check_val("s0_wr_ptr", 32'(bus.wr_ptr), 32'd1);
    check_val("s0_fill", 32'(bus.fill), 32'd1);
    bus.lowest_state = 8'hA5;
    read_chk(0, 8'h01, 1'b0, 1'b1, "s0_st01");
    check_val("done_pulse_end", 32'(bus.symbol_done), 32'd0);
    check_val("start_a5", 32'(bus.start_state), 32'hA5);
    bus.lowest_state = 8'h3C;
    read_chk(0, 8'h00, 1'b0, 1'b0, "s0_st00");
    check_val("start_hold", 32'(bus.start_state), 32'hA5);
    @(negedge clk);
    check_val("idle_valid", 32'(bus.rd_valid), 32'd0);
    check_val("idle_miss", 32'(bus.rd_miss), 32'd0);
    check_val("idle_bit", 32'(bus.rd_bit), 32'd0);

    // Hold without Active must not commit
    bus.hold = 1'b1;
    @(negedge clk);
    bus.hold = 1'b0;
    check_val("hold_only_done", 32'(bus.symbol_done), 32'd0);
    check_val("hold_only_fill", 32'(bus.fill), 32'd1);
    check_val("hold_only_ptr", 32'(bus.wr_ptr), 32'd1);

    for (int n = 1; n < 3; n++) send_symbol(n);
    check_val("s2_fill", 32'(bus.fill), 32'd3);
    read_chk(5, 8'h00, 1'b1, 1'b0, "miss5");
    read_chk(3, 8'h01, 1'b1, 1'b0, "miss_eq_fill");
    read_chk(2, 8'h01, 1'b0, exp_bit(0, 8'h01), "depth2");
    read_chk(1, 8'h57, 1'b0, exp_bit(1, 8'h57), "depth1");
    read_chk(0, 8'hC6, 1'b0, exp_bit(2, 8'hC6), "depth0");

    // Fill up and wrap: symbols 3..32
    for (int n = 3; n < 33; n++) begin
      send_symbol(n);
      check_val($sformatf("fill_%0d", n), 32'(bus.fill), (n + 1 > 32) ? 32'd32 : 32'(n + 1));
      check_val($sformatf("ready_%0d", n), 32'(bus.tb_ready), (n + 1 >= 32) ? 32'd1 : 32'd0);
      check_val($sformatf("ptr_%0d", n), 32'(bus.wr_ptr), 32'((n + 1) % 32));
    end
    read_chk(31, 8'h01, 1'b0, exp_bit(1, 8'h01), "wrap31_01");
    read_chk(31, 8'h9E, 1'b0, exp_bit(1, 8'h9E), "wrap31_9e");
    read_chk(31, 8'hFF, 1'b0, exp_bit(1, 8'hFF), "wrap31_ff");
    read_chk(0, 8'h42, 1'b0, exp_bit(32, 8'h42), "wrap0_42");

    // Read of the slot being overwritten on the commit cycle, then the new word
    for (int seg = 0; seg < 64; seg++) begin
      bus.active      = 1'b1;
      bus.acs_segment = 6'(seg);
      bus.survivors   = surv_of(33, seg);
      bus.hold        = (seg == 63);
      if (seg == 63) begin
        bus.rd_req = 1'b1; bus.rd_depth = 5'd31; bus.rd_state = 8'h01;
      end
      @(negedge clk);
    end
    bus.active = 1'b0; bus.hold = 1'b0;
    bus.rd_depth = 5'd0;
    check_val("ovw_old_valid", 32'(bus.rd_valid), 32'd1);
    check_val("ovw_old_bit", 32'(bus.rd_bit), 32'(exp_bit(1, 8'h01)));
    @(negedge clk);
    bus.rd_req = 1'b0;
    check_val("ovw_new_bit", 32'(bus.rd_bit), 32'(exp_bit(33, 8'h01)));
    check_val("ovw_ptr", 32'(bus.wr_ptr), 32'd2);
    check_val("ovw_fill", 32'(bus.fill), 32'd32);
    check_val("seg_err_clean", 32'(bus.seg_err), 32'd0);

    // Out-of-order segments 0,1,3
    for (int i = 0; i < 3; i++) begin
      bus.active      = 1'b1;
      bus.acs_segment = (i == 2) ? 6'd3 : 6'(i);
      bus.survivors   = 4'hF;
      @(negedge clk);
    end
    bus.active = 1'b0;
`ifdef SURV_SEGCHK_EN
    check_val("seg_err_set", 32'(bus.seg_err), 32'd1);
    repeat (3) @(negedge clk);
    check_val("seg_err_held", 32'(bus.seg_err), 32'd1);
`else
    check_val("seg_err_off", 32'(bus.seg_err), 32'd0);
`endif

    // Reset in the middle of a symbol, with a read in flight
    for (int seg = 0; seg < 10; seg++) begin
      bus.active = 1'b1; bus.acs_segment = 6'(seg); bus.survivors = 4'h6;
      @(negedge clk);
    end
    bus.rd_req = 1'b1; bus.rd_depth = 5'd0; bus.rd_state = 8'h00;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    bus.active = 1'b0; bus.rd_req = 1'b0;
    check_val("mid_rst_valid", 32'(bus.rd_valid), 32'd0);
    check_val("mid_rst_ptr", 32'(bus.wr_ptr), 32'd0);
    check_val("mid_rst_fill", 32'(bus.fill), 32'd0);
    check_val("mid_rst_ready", 32'(bus.tb_ready), 32'd0);
    check_val("mid_rst_start", 32'(bus.start_state), 32'd0);
    check_val("mid_rst_seg_err", 32'(bus.seg_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_symbol(40);
    check_val("post_rst_ptr", 32'(bus.wr_ptr), 32'd1);
    check_val("post_rst_fill", 32'(bus.fill), 32'd1);
    read_chk(0, 8'h00, 1'b0, exp_bit(40, 8'h00), "post_rst_00");
    read_chk(0, 8'h2B, 1'b0, exp_bit(40, 8'h2B), "post_rst_2b");
    read_chk(1, 8'h2B, 1'b1, 1'b0, "post_rst_miss");
    check_val("post_rst_seg_err", 32'(bus.seg_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
